circle_job_sched: RTL and testbench

Job scheduler that sits in front of a single `circle` drawing engine and the VGA adapter. It queues circle draw requests (colour, centre, radius) in a small FIFO and issues them to the engine one at a time. Because the engine latches `done` until its own reset, the scheduler restarts it with a reset pulse before every job. While a job runs, it forwards the engine's pixel stream to the VGA port, and it aborts any job that overruns a cycle budget.

---
 rtl/circle_job_sched.sv | 140 ++++++++++++++
 tb/tb_circle_job_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circle_job_sched.sv
// Queues circle draw jobs and runs them one at a time on a single circle engine,
// pulsing the engine's reset before each job and aborting jobs that overrun a cycle budget.
module circle_job_sched #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_colour,
  input  logic [7:0]  req_cx,
  input  logic [6:0]  req_cy,
  input  logic [7:0]  req_radius,
  output logic        eng_rst_n,
  output logic        eng_start,
  output logic [2:0]  eng_colour,
  output logic [7:0]  eng_cx,
  output logic [6:0]  eng_cy,
  output logic [7:0]  eng_radius,
  input  logic        eng_done,
  input  logic [7:0]  eng_x,
  input  logic [6:0]  eng_y,
  input  logic        eng_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic [7:0]  jobs_done,
  output logic [15:0] pixels,
  output logic        err
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned WdW  = $clog2(MAX_CYCLES);
  localparam logic [PtrW:0]  Full   = (PtrW + 1)'(DEPTH);
  localparam logic [WdW-1:0] WdLast = WdW'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StClr, StRun, StDrain} state_e;

  state_e          r_state, w_state_next;
  logic [25:0]     r_mem [DEPTH];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [PtrW:0]   r_count;
  logic [25:0]     r_job;
  logic [WdW-1:0]  r_wdog;
  logic [7:0]      r_jobs_done;
  logic [15:0]     r_pixels;
  logic            r_err;
  logic            w_push, w_pop, w_wd_hit, w_clr;

  assign req_ready = (r_count != Full);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == StIdle) && (r_count != '0);
  assign w_wd_hit  = (r_wdog == WdLast);

  always_comb begin
    w_state_next = r_state;
    eng_start    = 1'b0;
    w_clr        = 1'b0;
    unique case (r_state)
      StIdle:  if (w_pop) w_state_next = StClr;
      StClr: begin
        w_clr        = 1'b1;
        w_state_next = StRun;
      end
      StRun: begin
        eng_start = 1'b1;
        if (eng_done || w_wd_hit) w_state_next = StDrain;
      end
      StDrain: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {req_colour, req_cx, req_cy, req_radius};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_job   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
        r_job  <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW + 1)'(1);
        2'b01:   r_count <= r_count - (PtrW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Watchdog holds at its limit rather than wrapping; DRAIN always follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (r_state == StRun && !w_wd_hit) begin
      r_wdog <= r_wdog + WdW'(1);
    end else if (r_state == StDrain) begin
      r_wdog <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_jobs_done <= '0;
      r_pixels    <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == StRun && eng_done) r_jobs_done <= r_jobs_done + 8'd1;
      else if (r_state == StRun && w_wd_hit) r_err <= 1'b1;
      if (vga_plot && r_pixels != 16'hFFFF) r_pixels <= r_pixels + 16'd1;
    end
  end

  assign eng_rst_n = ~rst & ~w_clr;
  assign {eng_colour, eng_cx, eng_cy, eng_radius} = r_job;
  assign vga_x      = eng_x;
  assign vga_y      = eng_y;
  assign vga_colour = eng_colour;
  assign vga_plot   = eng_plot & eng_start;
  assign busy       = (r_count != '0) || (r_state != StIdle);
  assign jobs_done  = r_jobs_done;
  assign pixels     = r_pixels;
  assign err        = r_err;

endmodule

// File: tb/tb_circle_job_sched.sv
// Bench for circle_job_sched: mock circle engine, queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_circle_job_sched;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXC  = 64;
  localparam int PH_IDLE = 0, PH_CLR = 1, PH_RUN = 2, PH_DRAIN = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_colour = '0;
  logic [7:0] req_cx = '0;
  logic [6:0] req_cy = '0;
  logic [7:0] req_radius = '0;
  logic       req_ready, eng_rst_n, eng_start;
  logic [2:0] eng_colour;
  logic [7:0] eng_cx, eng_radius;
  logic [6:0] eng_cy;
  logic       eng_done, eng_plot;
  logic [7:0] eng_x = '0;
  logic [6:0] eng_y = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, err;
  logic [7:0] jobs_done;
  logic [15:0] pixels;

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  circle_job_sched #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_colour(req_colour), .req_cx(req_cx), .req_cy(req_cy), .req_radius(req_radius),
    .eng_rst_n(eng_rst_n), .eng_start(eng_start), .eng_colour(eng_colour), .eng_cx(eng_cx),
    .eng_cy(eng_cy), .eng_radius(eng_radius), .eng_done(eng_done), .eng_x(eng_x),
    .eng_y(eng_y), .eng_plot(eng_plot), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .jobs_done(jobs_done),
    .pixels(pixels), .err(err)
  );

  // Mock engine: plots `target` pixels while started, then latches done until reset.
  logic        stall = 1'b0, plot_auto = 1'b0, noise_en = 1'b0, noise = 1'b0;
  int unsigned plot_n = 0, e_cnt = 0, e_target;
  logic        e_done = 1'b0;

  always_comb e_target = plot_auto ? 32'(eng_radius[5:0]) : plot_n;

  always @(posedge clk) begin
    eng_x <= 8'($urandom);
    eng_y <= 7'($urandom);
    noise <= noise_en && ($urandom_range(0, 1) == 1);
    if (!eng_rst_n) begin
      e_cnt  <= 0;
      e_done <= 1'b0;
    end else if (eng_start && !stall && !e_done) begin
      if (e_cnt == e_target) e_done <= 1'b1;
      else e_cnt <= e_cnt + 1;
    end
  end

  assign eng_done = e_done;
  assign eng_plot = eng_start ? (!stall && !e_done && e_cnt < e_target) : noise;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: job queue plus current phase, advanced once per cycle.
  typedef struct packed {
    logic [2:0] c;
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] r;
  } job_t;

  job_t        m_q[$];
  job_t        m_job = '0;
  int          m_ph = PH_IDLE, m_run = 0;
  int unsigned m_jobs = 0, m_pix = 0;
  logic        m_err = 1'b0;
  logic        preload_req = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_job  = '0;
    m_ph   = PH_IDLE;
    m_run  = 0;
    m_jobs = 0;
    m_pix  = 0;
    m_err  = 1'b0;
  endtask

  task automatic compare();
    chk("req_ready", req_ready, m_q.size() != DEPTH);
    chk("busy", busy, (m_q.size() != 0) || (m_ph != PH_IDLE));
    chk("eng_start", eng_start, m_ph == PH_RUN);
    chk("eng_rst_n", eng_rst_n, !rst && (m_ph != PH_CLR));
    chk("eng_job", {eng_colour, eng_cx, eng_cy, eng_radius}, m_job);
    chk("vga_xy", {vga_x, vga_y}, {eng_x, eng_y});
    chk("vga_colour", vga_colour, m_job.c);
    chk("vga_plot", vga_plot, eng_plot && (m_ph == PH_RUN));
    chk("jobs_done", jobs_done, m_jobs);
    chk("pixels", pixels, m_pix);
    chk("err", err, m_err);
  endtask

  task automatic model_step();
    bit   push;
    job_t nj;
    push = req_valid && (m_q.size() < DEPTH);
    nj   = {req_colour, req_cx, req_cy, req_radius};
    case (m_ph)
      PH_IDLE: if (m_q.size() > 0) begin
        m_job = m_q.pop_front();
        m_ph  = PH_CLR;
      end
      PH_CLR: begin
        m_ph  = PH_RUN;
        m_run = 0;
      end
      PH_RUN: begin
        m_run++;
        if (eng_plot && m_pix < 65535) m_pix++;
        if (eng_done) begin
          m_jobs = (m_jobs + 1) % 256;
          m_ph   = PH_DRAIN;
        end else if (m_run == MAXC) begin
          m_err = 1'b1;
          m_ph  = PH_DRAIN;
        end
      end
      default: m_ph = PH_IDLE;
    endcase
    if (push) m_q.push_back(nj);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      if (preload_req) m_pix = 32'hFFF0;
      compare();
      if (!rst) model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] c, input logic [7:0] x, input logic [6:0] y,
                         input logic [7:0] r);
    req_colour = c;
    req_cx     = x;
    req_cy     = y;
    req_radius = r;
  endtask

  task automatic push_wait(input logic [7:0] r);
    int n;
    n = 0;
    set_req(3'($urandom), 8'($urandom), 7'($urandom), r);
    req_valid = 1'b1;
    while (!req_ready && n < 500) begin
      tick();
      n++;
    end
    chk("push_accept", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, k, n, starts, cnt;
    int unsigned jd0;
    logic [7:0] seen [8];
    logic prev;

    // Reset values
    tick();
    tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_eng_rst_n", eng_rst_n, 0);
    chk("rst_busy", {busy, eng_start, vga_plot, err}, 0);
    chk("rst_counters", {jobs_done, pixels}, 0);
    rst = 1'b0;
    tick();

    // Single job: latency, one-cycle engine reset, 57 plots, noise gated outside RUN
    noise_en  = 1'b1;
    plot_n    = 57;
    set_req(3'b010, 8'd80, 7'd60, 8'd10);
    req_valid = 1'b1;
    chk("single_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("lat_k_start", {eng_start, eng_rst_n}, 2'b01);
    tick();
    chk("lat_k1_clr", {eng_start, eng_rst_n}, 2'b00);
    tick();
    chk("lat_k2_run", {eng_start, eng_rst_n}, 2'b11);
    chk("single_job", {eng_colour, eng_cx, eng_cy, eng_radius}, {3'b010, 8'd80, 7'd60, 8'd10});
    n = 0;
    while (!eng_done && n < 200) begin
      tick();
      n++;
    end
    chk("single_done_seen", eng_done, 1);
    tick();
    tick();
    chk("single_jobs_done", jobs_done, 1);
    chk("single_pixels", pixels, 57);
    chk("single_busy", busy, 0);

    // Backpressure: stalled engine, six offers, five accepted
    stall     = 1'b1;
    plot_auto = 1'b1;
    acc       = 0;
    for (int i = 0; i < 6; i++) begin
      set_req(3'($urandom), 8'($urandom), 7'($urandom), 8'(i + 1));
      req_valid = 1'b1;
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_ready_low", req_ready, 0);
    seen[0] = eng_radius;
    k       = 1;
    prev    = eng_start;
    stall   = 1'b0;
    n       = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
      if (eng_start && !prev && k < 8) begin
        seen[k] = eng_radius;
        k++;
      end
      prev = eng_start;
    end
    chk("bp_job_count", k, 5);
    for (int i = 0; i < 5; i++) chk("bp_radius_order", seen[i], i + 1);
    chk("bp_jobs_done", jobs_done, 6);

    // Watchdog: first job never finishes, second still completes
    stall     = 1'b1;
    plot_auto = 1'b0;
    plot_n    = 5;
    jd0       = jobs_done;
    push_wait(8'd20);
    push_wait(8'd7);
    n = 0;
    while (!eng_start && n < 20) begin
      tick();
      n++;
    end
    cnt = 0;
    while (eng_start && cnt < 300) begin
      cnt++;
      tick();
    end
    chk("wd_run_cycles", cnt, MAXC);
    chk("wd_err", err, 1);
    chk("wd_jobs_done", jobs_done, jd0);
    stall = 1'b0;
    wait_idle(500, "wd");
    chk("wd_next_job", jobs_done, jd0 + 1);
    chk("wd_err_sticky", err, 1);

    // Reset mid-job with two jobs queued
    plot_n = 40;
    push_wait(8'd1);
    push_wait(8'd2);
    push_wait(8'd3);
    n = 0;
    while (!eng_start && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_outs", {eng_rst_n, eng_start, vga_plot, busy, err}, 0);
    chk("mid_rst_counters", {jobs_done, pixels}, 0);
    tick();
    rst    = 1'b0;
    starts = 0;
    repeat (20) begin
      tick();
      if (eng_start) starts++;
    end
    chk("mid_rst_no_start", starts, 0);

    // Randomized traffic with occasional resets
    plot_auto = 1'b1;
    repeat (1500) begin
      req_valid = ($urandom_range(0, 2) == 0);
      set_req(3'($urandom), 8'($urandom), 7'($urandom), 8'($urandom));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    req_valid = 1'b0;
    rst       = 1'b0;
    wait_idle(3000, "rand");

    // jobs_done wraps on the 256th completion
    plot_auto = 1'b0;
    plot_n    = 0;
    n         = 0;
    while (jobs_done != 8'd255 && n < 300) begin
      push_wait(8'($urandom));
      wait_idle(50, "wrap_step");
      n++;
    end
    chk("wrap_at_255", jobs_done, 255);
    push_wait(8'd9);
    wait_idle(50, "wrap_last");
    chk("wrap_to_0", jobs_done, 0);

    // pixels saturates at 0xFFFF
    plot_n = 40;
    force dut.r_pixels = 16'hFFF0;
    preload_req = 1'b1;
    tick();
    release dut.r_pixels;
    preload_req = 1'b0;
    chk("sat_preload", pixels, 16'hFFF0);
    push_wait(8'd4);
    wait_idle(200, "sat");
    chk("sat_hold", pixels, 16'hFFFF);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
